// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - issue/capture stage wrapping the 4-bit combinational ALU
module alu_issue_stage #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_op,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic       alu_l,
    output logic       alu_m,
    output logic       alu_n,
    input  logic [3:0] alu_s,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_result,
    output logic [2:0] out_op,
    output logic       out_zero,
    output logic       out_err
);

    typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);
    localparam logic [2:0] OP_RSVD  = 3'b111;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] a_q, a_d, b_q, b_d;
    logic [2:0] op_q, op_d;
    logic [3:0] res_q, res_d;
    logic [2:0] rop_q, rop_d;
    logic       zero_q, zero_d;
    logic       err_q, err_d;
    logic       accept;

    // DONE with out_ready releases the held result and may accept on the same edge.
    assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        rop_d   = rop_q;
        zero_d  = zero_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (accept) state_d = SETTLE;
            end
            SETTLE: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = DONE;
                    rop_d   = op_q;
                    if (op_q == OP_RSVD) begin
                        res_d  = 4'd0;
                        zero_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        res_d  = alu_s;
                        zero_d = (alu_s == 4'd0);
                        err_d  = 1'b0;
                    end
                end
            end
            DONE: begin
                if (out_ready) state_d = in_valid ? SETTLE : IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            a_d   = in_a;
            b_d   = in_b;
            op_d  = in_op;
            cnt_d = CNT_INIT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            a_q     <= 4'd0;
            b_q     <= 4'd0;
            op_q    <= 3'd0;
            res_q   <= 4'd0;
            rop_q   <= 3'd0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            rop_q   <= rop_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
        end
    end

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_l      = op_q[2];
    assign alu_m      = op_q[1];
    assign alu_n      = op_q[0];
    assign out_valid  = (state_q == DONE);
    assign out_result = res_q;
    assign out_op     = rop_q;
    assign out_zero   = zero_q;
    assign out_err    = err_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - self-checking bench for alu_issue_stage
module tb_alu_issue_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic       in_valid, in_ready, out_ready, out_valid;
    logic       alu_l, alu_m, alu_n, out_zero, out_err;
    logic [2:0] in_op, out_op;
    logic [3:0] in_a, in_b, alu_a, alu_b, alu_s, out_result;

    logic       d4_in_valid, d4_in_ready, d4_out_ready, d4_out_valid;
    logic       d4_alu_l, d4_alu_m, d4_alu_n, d4_out_zero, d4_out_err;
    logic [2:0] d4_in_op, d4_out_op;
    logic [3:0] d4_in_a, d4_in_b, d4_alu_a, d4_alu_b, d4_alu_s, d4_out_result;

    int checks = 0;
    int errors = 0;

    // Gate-level style ALU stand-in; reserved op produces deliberate garbage.
    function automatic logic [3:0] alu_model(input logic l, m, n, input logic [3:0] a, b);
        case ({l, m, n})
            3'b000:  return ~a + 4'd1;
            3'b001:  return ~b + 4'd1;
            3'b010:  return a + b;
            3'b011:  return a + ~b + 4'd1;
            3'b100:  return a & b;
            3'b101:  return a | b;
            3'b110:  return a * b;
            default: return a ^ b ^ 4'h9;
        endcase
    endfunction

    function automatic int ref_result(input int op, input int a, input int b);
        case (op)
            0:       return (16 - a) % 16;
            1:       return (16 - b) % 16;
            2:       return (a + b) % 16;
            3:       return (a + 16 - b) % 16;
            4:       return a & b;
            5:       return a | b;
            6:       return (a * b) % 16;
            default: return 0;
        endcase
    endfunction

    assign alu_s    = alu_model(alu_l, alu_m, alu_n, alu_a, alu_b);
    assign d4_alu_s = alu_model(d4_alu_l, d4_alu_m, d4_alu_n, d4_alu_a, d4_alu_b);

    alu_issue_stage #(.SETTLE_CYCLES(1)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_l(alu_l), .alu_m(alu_m), .alu_n(alu_n),
        .alu_s(alu_s), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_op(out_op), .out_zero(out_zero), .out_err(out_err)
    );

    alu_issue_stage #(.SETTLE_CYCLES(4)) u_dut4 (
        .clk(clk), .reset(reset), .in_valid(d4_in_valid), .in_ready(d4_in_ready),
        .in_op(d4_in_op), .in_a(d4_in_a), .in_b(d4_in_b),
        .alu_a(d4_alu_a), .alu_b(d4_alu_b), .alu_l(d4_alu_l), .alu_m(d4_alu_m), .alu_n(d4_alu_n),
        .alu_s(d4_alu_s), .out_valid(d4_out_valid), .out_ready(d4_out_ready),
        .out_result(d4_out_result), .out_op(d4_out_op), .out_zero(d4_out_zero), .out_err(d4_out_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_op(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] exp_res, input logic exp_zero, input logic exp_err,
                         input string tag);
        int n;
        in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin step(); n++; end
        chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk({tag, " alu_ab"}, {24'd0, alu_a, alu_b}, {24'd0, a, b});
        chk({tag, " alu_lmn"}, {29'd0, alu_l, alu_m, alu_n}, {29'd0, op});
        n = 0;
        while (!out_valid && n < 50) begin step(); n++; end
        chk({tag, " latency"}, 32'(n), 32'd1);
        chk({tag, " result"}, {25'd0, out_op, out_result}, {25'd0, op, exp_res});
        chk({tag, " flags"}, {30'd0, out_zero, out_err}, {30'd0, exp_zero, exp_err});
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, " released"}, 32'(out_valid), 32'd0);
    endtask

    typedef struct {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] res;
        logic       zero;
        logic       err;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int n, hits;
        logic [2:0] rop;
        logic [3:0] ra, rb, rexp;

        vecs[0] = '{3'b010, 4'd5,    4'd3,    4'b1000, 1'b0, 1'b0};
        vecs[1] = '{3'b011, 4'd3,    4'd5,    4'b1110, 1'b0, 1'b0};
        vecs[2] = '{3'b000, 4'b0001, 4'd0,    4'b1111, 1'b0, 1'b0};
        vecs[3] = '{3'b110, 4'd3,    4'd5,    4'b1111, 1'b0, 1'b0};
        vecs[4] = '{3'b110, 4'd6,    4'd3,    4'b0010, 1'b0, 1'b0};
        vecs[5] = '{3'b100, 4'b1100, 4'b1010, 4'b1000, 1'b0, 1'b0};
        vecs[6] = '{3'b011, 4'd7,    4'd7,    4'b0000, 1'b1, 1'b0};
        vecs[7] = '{3'b111, 4'd9,    4'd4,    4'b0000, 1'b1, 1'b1};
        vecs[8] = '{3'b010, 4'd1,    4'd1,    4'b0010, 1'b0, 1'b0};
        vecs[9] = '{3'b001, 4'd0,    4'd1,    4'b1111, 1'b0, 1'b0};

        reset = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; in_op = '0; in_a = '0; in_b = '0;
        d4_in_valid = 1'b0; d4_out_ready = 1'b0; d4_in_op = '0; d4_in_a = '0; d4_in_b = '0;
        step(); step();
        reset = 1'b0;

        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset outputs", {22'd0, out_result, out_op, out_zero, out_err}, 32'd0);
        chk("reset alu", {21'd0, alu_a, alu_b, alu_l, alu_m, alu_n}, 32'd0);

        for (int i = 0; i < 10; i++)
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].zero, vecs[i].err,
                  $sformatf("vec%0d", i));

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rexp = 4'(ref_result(int'(rop), int'(ra), int'(rb)));
            do_op(rop, ra, rb, rexp, (rexp == 4'd0), (rop == 3'b111), $sformatf("rnd%0d", i));
        end

        // Backpressure with a pending offer, then back-to-back release/accept.
        in_op = 3'b010; in_a = 4'd2; in_b = 4'd3; in_valid = 1'b1;
        step();
        in_op = 3'b101; in_a = 4'd9; in_b = 4'd6;
        n = 0;
        while (!out_valid && n < 50) begin step(); n++; end
        chk("bp first result", 32'(out_result), 32'd5);
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("bp hold%0d", i), {23'd0, out_valid, in_ready, out_result, alu_a},
                {23'd0, 1'b1, 1'b0, 4'd5, 4'd2});
        end
        out_ready = 1'b1;
        #1;
        chk("bp in_ready comb", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        chk("b2b accepted", {27'd0, out_valid, alu_a}, {27'd0, 1'b0, 4'd9});
        n = 0;
        while (!out_valid && n < 50) begin step(); n++; end
        chk("b2b latency", 32'(n), 32'd1);
        chk("b2b result", {25'd0, out_op, out_result}, {25'd0, 3'b101, 4'hF});
        out_ready = 1'b1; step(); out_ready = 1'b0;

        // SETTLE_CYCLES=4: reset mid-settle discards the operation.
        d4_in_op = 3'b010; d4_in_a = 4'd4; d4_in_b = 4'd4; d4_in_valid = 1'b1;
        step();
        d4_in_valid = 1'b0;
        step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("s4 reset idle", {25'd0, d4_in_ready, d4_out_valid, d4_alu_l, d4_alu_m, d4_alu_n, 2'd0},
            {25'd0, 1'b1, 1'b0, 5'd0});
        chk("s4 reset alu", {24'd0, d4_alu_a, d4_alu_b}, 32'd0);
        hits = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (d4_out_valid) hits++;
        end
        chk("s4 nothing emitted", 32'(hits), 32'd0);

        d4_in_op = 3'b110; d4_in_a = 4'd3; d4_in_b = 4'd5; d4_in_valid = 1'b1;
        step();
        d4_in_valid = 1'b0;
        n = 0;
        while (!d4_out_valid && n < 50) begin step(); n++; end
        chk("s4 latency", 32'(n), 32'd4);
        chk("s4 result", {23'd0, d4_out_op, d4_out_result, d4_out_zero, d4_out_err},
            {23'd0, 3'b110, 4'hF, 1'b0, 1'b0});
        d4_out_ready = 1'b1; step(); d4_out_ready = 1'b0;
        chk("s4 released", 32'(d4_out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
